// File: rtl/operand2_shifter_unit.sv
// operand2_shifter_unit: pipelined, valid/ready wrapped ARM operand-2 generator.
// Produces the ALU second operand and shifter carry-out from one of four sources:
// memory offset, rotated immediate, immediate-amount shift of Rm, or
// register-amount shift of Rm by Rs[7:0]. Register-amount shifts spend one
// extra cycle in CALC.
//
// Handshake: a request transfers on in_valid && in_ready; a result transfers on
// out_valid && out_ready. A producer holding valid must keep its payload stable
// until the transfer; out_valid/val2/carry_out stay stable while out_ready is low.
//
// Optional build macro OPERAND2_RRX_EN: when defined, immediate ROR #0 is RRX.
module operand2_shifter_unit #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 8,
  parameter int ROT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              imm,
  input  logic              mem_mode,
  input  logic [11:0]       shift_operand,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [DATA_W-1:0] val_rs,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2,
  output logic              carry_out
);

  typedef enum logic [1:0] {IDLE, CALC, FULL} state_t;

  localparam logic [8:0] W9     = 9'(DATA_W);
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;

  // Shift rm by amt with register-shift semantics; returns {carry, value}.
  function automatic logic [DATA_W:0] shift_by(
    input logic [DATA_W-1:0] rm,
    input logic [1:0]        typ,
    input logic [7:0]        amt,
    input logic              cin
  );
    logic [8:0]        n9;
    logic [8:0]        r9;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] tmp;
    logic              c;
    n9  = {1'b0, amt};
    r9  = n9 & (W9 - 9'd1);
    val = rm;
    c   = cin;
    tmp = '0;
    if (n9 != 9'd0) begin
      case (typ)
        SH_LSL: begin
          if (n9 < W9) begin
            val = rm << n9;
            tmp = rm >> (W9 - n9);
            c   = tmp[0];
          end else begin
            val = '0;
            c   = (n9 == W9) ? rm[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (n9 < W9) begin
            val = rm >> n9;
            tmp = rm >> (n9 - 9'd1);
            c   = tmp[0];
          end else begin
            val = '0;
            c   = (n9 == W9) ? rm[DATA_W-1] : 1'b0;
          end
        end
        SH_ASR: begin
          if (n9 < W9) begin
            val = $unsigned($signed(rm) >>> n9);
            tmp = rm >> (n9 - 9'd1);
            c   = tmp[0];
          end else begin
            val = {DATA_W{rm[DATA_W-1]}};
            c   = rm[DATA_W-1];
          end
        end
        default: begin
          // ROR: amount is taken modulo the width; a full turn keeps Rm.
          if (r9 == 9'd0) begin
            c = rm[DATA_W-1];
          end else begin
            val = (rm >> r9) | (rm << (W9 - r9));
            tmp = rm >> (r9 - 9'd1);
            c   = tmp[0];
          end
        end
      endcase
    end
    return {c, val};
  endfunction

  state_t            state_q, state_d;
  logic [DATA_W-1:0] val2_q, val2_d;
  logic              carry_out_q, carry_out_d;
  logic [DATA_W-1:0] rm_q, rm_d;
  logic [7:0]        rs_q, rs_d;
  logic [1:0]        typ_q, typ_d;
  logic              cin_q, cin_d;

  logic              accept;
  logic              is_reg;
  logic [DATA_W:0]   live_res;
  logic [DATA_W:0]   calc_res;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] imm_rot;
  logic [8:0]        rot9;
  logic [4:0]        sh_amt;
  logic [1:0]        sh_typ;
  logic              unused_rs_hi;

  assign unused_rs_hi = ^val_rs[DATA_W-1:8];

  assign in_ready  = (state_q == IDLE) || ((state_q == FULL) && out_ready);
  assign out_valid = (state_q == FULL);
  assign val2      = val2_q;
  assign carry_out = carry_out_q;
  assign accept    = in_valid && in_ready;
  assign is_reg    = !mem_mode && !imm && shift_operand[4];

  // Single-cycle result for memory, immediate and immediate-shift requests.
  always_comb begin
    imm_ext  = {{(DATA_W-IMM_W){1'b0}}, shift_operand[IMM_W-1:0]};
    rot9     = 9'({shift_operand[IMM_W +: ROT_W], 1'b0});
    imm_rot  = (imm_ext >> rot9) | (imm_ext << (W9 - rot9));
    sh_amt   = shift_operand[11:7];
    sh_typ   = shift_operand[6:5];
    live_res = {carry_in, val_rm};
    if (mem_mode) begin
      live_res = {carry_in, {(DATA_W-12){1'b0}}, shift_operand};
    end else if (imm) begin
      live_res = {(rot9 == 9'd0) ? carry_in : imm_rot[DATA_W-1], imm_rot};
    end else if (sh_amt != 5'd0) begin
      live_res = shift_by(val_rm, sh_typ, {3'b000, sh_amt}, carry_in);
    end else begin
      case (sh_typ)
        SH_LSR, SH_ASR: live_res = shift_by(val_rm, sh_typ, 8'd32, carry_in);
        SH_LSL:         live_res = {carry_in, val_rm};
        default: begin
`ifdef OPERAND2_RRX_EN
          live_res = {val_rm[0], carry_in, val_rm[DATA_W-1:1]};
`else
          live_res = {carry_in, val_rm};
`endif
        end
      endcase
    end
  end

  // Register-amount shift computed from the operands captured on accept.
  always_comb begin
    calc_res = shift_by(rm_q, typ_q, rs_q, cin_q);
  end

  // Next-state and datapath-register update.
  always_comb begin
    state_d     = state_q;
    val2_d      = val2_q;
    carry_out_d = carry_out_q;
    rm_d        = rm_q;
    rs_d        = rs_q;
    typ_d       = typ_q;
    cin_d       = cin_q;
    case (state_q)
      IDLE, FULL: begin
        if (accept) begin
          if (is_reg) begin
            state_d = CALC;
            rm_d    = val_rm;
            rs_d    = val_rs[7:0];
            typ_d   = shift_operand[6:5];
            cin_d   = carry_in;
          end else begin
            state_d                = FULL;
            {carry_out_d, val2_d}  = live_res;
          end
        end else if ((state_q == FULL) && out_ready) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        state_d               = FULL;
        {carry_out_d, val2_d} = calc_res;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      val2_q      <= '0;
      carry_out_q <= 1'b0;
      rm_q        <= '0;
      rs_q        <= '0;
      typ_q       <= '0;
      cin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      val2_q      <= val2_d;
      carry_out_q <= carry_out_d;
      rm_q        <= rm_d;
      rs_q        <= rs_d;
      typ_q       <= typ_d;
      cin_q       <= cin_d;
    end
  end

endmodule

// File: tb/tb_operand2_shifter_unit.sv
// Bench for operand2_shifter_unit (DATA_W=32). Honours OPERAND2_RRX_EN.
module tb_operand2_shifter_unit;

  typedef struct packed {
    logic        imm;
    logic        mem;
    logic [11:0] so;
    logic [31:0] rm;
    logic [31:0] rs;
    logic        cin;
    logic [1:0]  lat;
    logic [32:0] exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, imm, mem_mode, carry_in;
  logic [11:0] shift_operand;
  logic [31:0] val_rm, val_rs, val2;
  logic        out_valid, out_ready, carry_out;

  always #5 clk = ~clk;

  operand2_shifter_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .mem_mode(mem_mode), .shift_operand(shift_operand),
    .val_rm(val_rm), .val_rs(val_rs), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .val2(val2), .carry_out(carry_out)
  );

  logic [32:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // ---------------- reference model (bit-serial) ----------------
  function automatic logic [32:0] model(input logic i_imm, input logic i_mem,
                                        input logic [11:0] so, input logic [31:0] rm,
                                        input logic [31:0] rs, input logic cin);
    logic [31:0] v;
    logic        c;
    logic [1:0]  t;
    int          n;
    v = rm; c = cin; t = so[6:5]; n = 0;
    if (i_mem) begin
      v = {20'd0, so};
    end else if (i_imm) begin
      v = {24'd0, so[7:0]};
      for (int k = 0; k < 2 * int'(so[11:8]); k++) v = {v[0], v[31:1]};
      c = (so[11:8] == 4'd0) ? cin : v[31];
    end else begin
      if (so[4]) n = int'(rs[7:0]);
      else begin
        n = int'(so[11:7]);
        if (n == 0 && (t == 2'b01 || t == 2'b10)) n = 32;
`ifdef OPERAND2_RRX_EN
        if (n == 0 && t == 2'b11) begin v = {cin, rm[31:1]}; c = rm[0]; end
`endif
      end
      for (int k = 0; k < n; k++) begin
        case (t)
          2'b00:   begin c = v[31]; v = {v[30:0], 1'b0}; end
          2'b01:   begin c = v[0];  v = {1'b0, v[31:1]}; end
          2'b10:   begin c = v[0];  v = {v[31], v[31:1]}; end
          default: begin c = v[0];  v = {v[0], v[31:1]}; end
        endcase
      end
    end
    return {c, v};
  endfunction

  function automatic vec_t mk(input logic i_imm, input logic i_mem, input logic [11:0] so,
                              input logic [31:0] rm, input logic [31:0] rs, input logic cin,
                              input logic [1:0] lat, input logic [32:0] exp);
    vec_t v;
    v.imm = i_imm; v.mem = i_mem; v.so = so; v.rm = rm; v.rs = rs; v.cin = cin;
    v.lat = lat; v.exp = exp;
    return v;
  endfunction

  function automatic vec_t rand_vec(input bit allow_reg);
    vec_t v;
    int   m;
    m = $urandom_range(0, 7);
    v.mem = (m == 0);
    v.imm = (m == 1 || m == 2);
    v.so  = 12'($urandom);
    if (!allow_reg) v.so[4] = 1'b0;
    v.rm  = $urandom;
    v.rs  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 70)) : $urandom;
    v.cin = 1'($urandom);
    v.lat = (!v.mem && !v.imm && v.so[4]) ? 2'd2 : 2'd1;
    v.exp = model(v.imm, v.mem, v.so, v.rm, v.rs, v.cin);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    imm = v.imm; mem_mode = v.mem; shift_operand = v.so;
    val_rm = v.rm; val_rs = v.rs; carry_in = v.cin;
  endtask

  // Present one request and hold it until accepted; pushes its expectation.
  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    drive(v);
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (ok) exp_q.push_back(v.exp);
    else begin
      n_checks++;
      $display("FAIL send_timeout: in_ready never high (got 0, need 1)");
    end
  endtask

  // Returns the number of negedges until out_valid, or -1 on timeout.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int          lat;
    logic [32:0] e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(mk(0, 0, 12'h0, 32'h0, 32'h0, 0, 1, 33'h0));
    #12;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b need 0", out_valid); else n_pass++;
    n_checks++; if (val2 !== 32'h0) $display("FAIL rst_val2: got %h need 0", val2); else n_pass++;
    n_checks++; if (carry_out !== 1'b0) $display("FAIL rst_carry: got %b need 0", carry_out); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b need 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    // Load a nonzero result, then reset while a register shift sits in CALC.
    send(mk(1, 0, 12'h4FF, 32'h0, 32'h0, 0, 1, 33'h1_FF000000));
    wait_out(lat);
    e = exp_q.pop_front();
    n_checks++; if ({carry_out, val2} !== e) $display("FAIL rst_preload: got %h need %h", {carry_out, val2}, e); else n_pass++;
    @(posedge clk); #1;
    send(mk(0, 0, 12'h010, 32'h3, 32'd1, 0, 2, 33'h0_00000006));
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midcalc_out_valid: got %b need 0", out_valid); else n_pass++;
    n_checks++; if (val2 !== 32'h0) $display("FAIL midcalc_val2: got %h need 0", val2); else n_pass++;
    n_checks++; if (carry_out !== 1'b0) $display("FAIL midcalc_carry: got %b need 0", carry_out); else n_pass++;
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL midcalc_in_ready: got %b need 1", in_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midcalc_discard: got %b need 0", out_valid); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t        vq[$];
    int          lat;
    logic [32:0] e;
    vq.push_back(mk(1, 0, 12'h4FF, 32'h0,        32'h0,   0, 1, 33'h1_FF000000));
    vq.push_back(mk(0, 0, 12'h040, 32'h80000000, 32'h0,   0, 1, 33'h1_FFFFFFFF));
    vq.push_back(mk(1, 1, 12'hABC, 32'h0,        32'h0,   1, 1, 33'h1_00000ABC));
    vq.push_back(mk(0, 0, 12'h000, 32'h12345678, 32'h0,   1, 1, 33'h1_12345678));
    vq.push_back(mk(0, 0, 12'h020, 32'h80000001, 32'h0,   0, 1, 33'h1_00000000));
    vq.push_back(mk(0, 0, 12'h080, 32'h80000001, 32'h0,   0, 1, 33'h1_00000002));
    vq.push_back(mk(1, 0, 12'h0AB, 32'h0,        32'h0,   1, 1, 33'h1_000000AB));
    vq.push_back(mk(0, 0, 12'h260, 32'h0000000F, 32'h0,   0, 1, 33'h1_F0000000));
    vq.push_back(mk(0, 0, 12'h240, 32'h80000010, 32'h0,   1, 1, 33'h0_F8000001));
    vq.push_back(mk(0, 0, 12'h010, 32'h00000003, 32'd33,  1, 2, 33'h0_00000000));
    vq.push_back(mk(0, 0, 12'h010, 32'h00000003, 32'd32,  0, 2, 33'h1_00000000));
    vq.push_back(mk(0, 0, 12'h030, 32'hDEADBEEF, 32'h100, 1, 2, 33'h1_DEADBEEF));
    vq.push_back(mk(0, 0, 12'h070, 32'h80000001, 32'd32,  0, 2, 33'h1_80000001));
    vq.push_back(mk(0, 0, 12'h070, 32'h0000000F, 32'd36,  0, 2, 33'h1_F0000000));
    vq.push_back(mk(0, 0, 12'h050, 32'h7FFFFFFF, 32'd200, 1, 2, 33'h0_00000000));
    vq.push_back(mk(0, 0, 12'h030, 32'h00000003, 32'd1,   0, 2, 33'h1_00000001));
    vq.push_back(mk(0, 1, 12'h010, 32'hFFFFFFFF, 32'd5,   0, 1, 33'h0_00000010));
    foreach (vq[i]) begin
      send(vq[i]);
      wait_out(lat);
      n_checks++;
      if (lat !== int'(vq[i].lat)) $display("FAIL dir%0d_latency: got %0d need %0d", i, lat, vq[i].lat);
      else n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if ({carry_out, val2} !== e) $display("FAIL dir%0d_result: got %h need %h", i, {carry_out, val2}, e);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rrx();
    int          lat;
    logic [32:0] e;
`ifdef OPERAND2_RRX_EN
    send(mk(0, 0, 12'h060, 32'h00000001, 32'h0, 1, 1, 33'h1_80000000));
`else
    send(mk(0, 0, 12'h060, 32'h00000001, 32'h0, 1, 1, 33'h1_00000001));
`endif
    wait_out(lat);
    e = exp_q.pop_front();
    n_checks++; if ({carry_out, val2} !== e) $display("FAIL rrx_result: got %h need %h", {carry_out, val2}, e); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    vec_t        v;
    int          lat;
    logic [32:0] e;
    for (int i = 0; i < 40; i++) begin
      v = rand_vec(1'b1);
      send(v);
      wait_out(lat);
      e = exp_q.pop_front();
      n_checks++;
      if ({carry_out, val2} !== e || lat !== int'(v.lat))
        $display("FAIL rand%0d: got %h lat %0d need %h lat %0d (so=%h rm=%h rs=%h)",
                 i, {carry_out, val2}, lat, e, v.lat, v.so, v.rm, v.rs);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    vec_t        v;
    logic [32:0] e;
    out_ready = 1'b0;
    send(rand_vec(1'b0));
    // Stall with a pending request whose inputs keep changing.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(rand_vec(1'b0));
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {carry_out, val2} !== exp_q[0])
        $display("FAIL stall%0d: got rdy=%b vld=%b res=%h need rdy=0 vld=1 res=%h",
                 i, in_ready, out_valid, {carry_out, val2}, exp_q[0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    v = rand_vec(1'b0);
    drive(v);
    out_ready = 1'b1;
    exp_q.push_back(v.exp);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (in_ready !== 1'b1 || {carry_out, val2} !== e)
      $display("FAIL release: got rdy=%b res=%h need rdy=1 res=%h", in_ready, {carry_out, val2}, e);
    else n_pass++;
    @(posedge clk); #1;
    // Continuous stream: one result per cycle.
    for (int j = 0; j < 6; j++) begin
      v = rand_vec(1'b0);
      drive(v);
      exp_q.push_back(v.exp);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || {carry_out, val2} !== e)
        $display("FAIL b2b%0d: got vld=%b res=%h need vld=1 res=%h", j, out_valid, {carry_out, val2}, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || {carry_out, val2} !== e)
      $display("FAIL b2b_last: got vld=%b res=%h need vld=1 res=%h", out_valid, {carry_out, val2}, e);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b need 0", out_valid); else n_pass++;
    @(posedge clk); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_rrx();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (got timeout, need finish)");
    $fatal(1);
  end

endmodule
